// File: rtl/ppe_pkg.sv
// Shared types and constants for the partial-PE convolution sequencer.
package ppe_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MAC,
      EMIT,
      ROWEND,
      REQ
   } state_e;

   localparam int OP_WEIGHT        = 0;
   localparam int OP_INPUT         = 1;
   localparam int OP_TIMESTEP_DONE = 15;
   localparam int IMEM_ID          = 10;
   localparam int WEIGHT_W         = 8;
   localparam int SUM_W            = 14;

   function automatic int output_dim(input int ifmap, input int filter);
      return ifmap - filter + 1;
   endfunction

endpackage

// File: rtl/ppe_mac_acc.sv
// Per-window multiply-accumulate: walks the weight RF one tap per cycle and
// adds the weight wherever the matching input spike is set.
module ppe_mac_acc #(
   parameter int TAPS  = 5,
   parameter int WGT_W = ppe_pkg::WEIGHT_W,
   parameter int ACC_W = ppe_pkg::SUM_W
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [TAPS-1:0]         taps_i,
   input  logic [WGT_W-1:0]        w_rdata_i,
   output logic [$clog2(TAPS)-1:0] w_raddr_o,
   output logic                    done_o,
   output logic [ACC_W-1:0]        acc_o
);
   import ppe_pkg::*;

   localparam int TW = $clog2(TAPS + 1);
   localparam int AW = $clog2(TAPS);
   localparam logic [TW-1:0] T_LAST = TW'(TAPS);

   logic [TW-1:0]    t_q, t_d, tap_idx;
   logic [ACC_W-1:0] acc_q, acc_d, w_ext;

   assign w_ext     = {{(ACC_W - WGT_W){w_rdata_i[WGT_W-1]}}, w_rdata_i};
   assign tap_idx   = t_q - 1'b1;
   assign w_raddr_o = (t_q < T_LAST) ? t_q[AW-1:0] : AW'(TAPS - 1);
   assign acc_o     = acc_q;

   // start_i is held for the whole MAC phase; rdata lags raddr by one cycle.
   always_comb begin
      t_d    = '0;
      acc_d  = acc_q;
      done_o = 1'b0;
      if (start_i) begin
         if (t_q == '0) begin
            acc_d = '0;
         end else if (taps_i[tap_idx]) begin
            acc_d = acc_q + w_ext;
         end
         if (t_q == T_LAST) begin
            done_o = 1'b1;
         end else begin
            t_d = t_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         t_q   <= '0;
         acc_q <= '0;
      end else begin
         t_q   <= t_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/ppe_conv_sequencer.sv
// Sequences one partial-PE 1-D convolution: row intake, per-window MAC,
// round-robin partial-sum emission and IMEM row requests.
module ppe_conv_sequencer #(
   parameter int FILTER_SIZE = 5,
   parameter int IFMAP_SIZE  = 25,
   parameter int WEIGHT_W    = ppe_pkg::WEIGHT_W,
   parameter int SUM_W       = ppe_pkg::SUM_W,
   parameter int PE_ID       = 0,
   parameter int IMEM_ID     = ppe_pkg::IMEM_ID
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           row_valid,
   output logic                           row_ready,
   input  logic [IFMAP_SIZE-1:0]          row_data,
   input  logic                           weights_loaded,
   output logic [$clog2(FILTER_SIZE)-1:0] w_raddr,
   input  logic [WEIGHT_W-1:0]            w_rdata,
   output logic                           ps_valid,
   input  logic                           ps_ready,
   output logic [SUM_W-1:0]               ps_data,
   output logic [3:0]                     ps_dest,
   output logic                           req_valid,
   input  logic                           req_ready,
   output logic [3:0]                     req_dest,
   output logic [3:0]                     req_pe_id,
   input  logic                           ts_done,
   output logic [1:0]                     ts,
   output logic                           busy
);
   import ppe_pkg::*;

   localparam int OUT_DIM = output_dim(IFMAP_SIZE, FILTER_SIZE);
   localparam int WINW    = $clog2(OUT_DIM + 1);
   localparam int RW      = $clog2(FILTER_SIZE + 1);
   localparam logic [WINW-1:0] WIN_END   = WINW'(OUT_DIM);
   localparam logic [RW-1:0]   ROWS_MAX  = RW'(FILTER_SIZE);
   localparam logic [3:0]      DEST_LAST = 4'(FILTER_SIZE - 1);

   state_e                 state_q, state_d;
   logic [IFMAP_SIZE-1:0]  row_q, row_d;
   logic [WINW-1:0]        win_q, win_d, win_nxt;
   logic [RW-1:0]          rows_q, rows_d;
   logic [3:0]             dest_q, dest_d;
   logic [1:0]             ts_q, ts_d;
   logic                   pend_q, pend_d;
   logic                   to_idle, mac_done;
   logic [FILTER_SIZE-1:0] taps;
   logic [SUM_W-1:0]       acc;

   assign taps      = FILTER_SIZE'(row_q >> win_q);
   assign win_nxt   = win_q + 1'b1;
   assign ps_data   = acc;
   assign ps_dest   = dest_q;
   assign ts        = ts_q;
   assign busy      = (state_q != IDLE);
   assign req_dest  = 4'(IMEM_ID);
   assign req_pe_id = 4'(PE_ID);

   ppe_mac_acc #(
      .TAPS  (FILTER_SIZE),
      .WGT_W (WEIGHT_W),
      .ACC_W (SUM_W)
   ) u_mac (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (state_q == MAC),
      .taps_i    (taps),
      .w_rdata_i (w_rdata),
      .w_raddr_o (w_raddr),
      .done_o    (mac_done),
      .acc_o     (acc)
   );

   // Valid/ready: a transfer happens on a cycle where both are high; a raised
   // valid and its payload hold until that cycle.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      win_d     = win_q;
      rows_d    = rows_q;
      dest_d    = dest_q;
      ts_d      = ts_q;
      pend_d    = pend_q;
      row_ready = 1'b0;
      ps_valid  = 1'b0;
      req_valid = 1'b0;
      to_idle   = 1'b0;
      if (state_q != IDLE && ts_done) pend_d = 1'b1;
      case (state_q)
         IDLE: begin
            row_ready = weights_loaded && (rows_q < ROWS_MAX);
            if (row_valid && row_ready) begin
               row_d   = row_data;
               rows_d  = rows_q + 1'b1;
               win_d   = '0;
               state_d = MAC;
               pend_d  = pend_q | ts_done;
            end else if (ts_done) begin
               ts_d   = (ts_q == 2'd1) ? 2'd2 : 2'd1;
               rows_d = '0;
               dest_d = '0;
            end
         end
         MAC: if (mac_done) state_d = EMIT;
         EMIT: begin
            ps_valid = 1'b1;
            if (ps_ready) begin
               dest_d  = (dest_q == DEST_LAST) ? 4'd0 : dest_q + 1'b1;
               win_d   = win_nxt;
               state_d = (win_nxt < WIN_END) ? MAC : ROWEND;
            end
         end
         ROWEND: begin
            if (rows_q < ROWS_MAX) begin
               state_d = REQ;
            end else begin
               state_d = IDLE;
               to_idle = 1'b1;
            end
         end
         REQ: begin
            req_valid = 1'b1;
            if (req_ready) begin
               state_d = IDLE;
               to_idle = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A deferred timestep end takes effect as the row finishes.
      if (to_idle && pend_d) begin
         ts_d   = (ts_q == 2'd1) ? 2'd2 : 2'd1;
         rows_d = '0;
         dest_d = '0;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         win_q   <= '0;
         rows_q  <= '0;
         dest_q  <= '0;
         ts_q    <= 2'd1;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         win_q   <= win_d;
         rows_q  <= rows_d;
         dest_q  <= dest_d;
         ts_q    <= ts_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_ppe_conv_sequencer.sv
// Directed bench for ppe_conv_sequencer with a behavioural weight RF.
module tb_ppe_conv_sequencer;
   localparam int FS = 5;
   localparam int IW = 25;
   localparam int WW = 8;
   localparam int SW = 14;
   localparam int ND = 21;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          row_valid = 1'b0;
   logic          weights_loaded = 1'b0;
   logic          ps_ready = 1'b1;
   logic          req_ready = 1'b1;
   logic          ts_done = 1'b0;
   logic [IW-1:0] row_data = '0;
   logic          row_ready, ps_valid, req_valid, busy;
   logic [2:0]    w_raddr;
   logic [WW-1:0] w_rdata;
   logic [SW-1:0] ps_data;
   logic [3:0]    ps_dest, req_dest, req_pe_id;
   logic [1:0]    ts;

   logic [WW-1:0] wrf[FS];
   logic [SW-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   int exp_dest = 0;
   int exp_ts = 1;

   ppe_conv_sequencer #(
      .FILTER_SIZE (FS), .IFMAP_SIZE (IW), .WEIGHT_W (WW), .SUM_W (SW),
      .PE_ID (0), .IMEM_ID (10)
   ) dut (
      .clk (clk), .rst_n (rst_n), .row_valid (row_valid), .row_ready (row_ready),
      .row_data (row_data), .weights_loaded (weights_loaded), .w_raddr (w_raddr),
      .w_rdata (w_rdata), .ps_valid (ps_valid), .ps_ready (ps_ready),
      .ps_data (ps_data), .ps_dest (ps_dest), .req_valid (req_valid),
      .req_ready (req_ready), .req_dest (req_dest), .req_pe_id (req_pe_id),
      .ts_done (ts_done), .ts (ts), .busy (busy)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) w_rdata <= wrf[w_raddr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic set_w(input int a, input int b, input int c, input int d, input int e);
      wrf[0] = WW'(a); wrf[1] = WW'(b); wrf[2] = WW'(c); wrf[3] = WW'(d); wrf[4] = WW'(e);
   endtask

   task automatic fill(input int first, input int rest);
      exp_q.push_back(SW'(first));
      for (int i = 1; i < ND; i++) exp_q.push_back(SW'(rest));
   endtask

   task automatic send_row(input logic [IW-1:0] r);
      int guard = 0;
      while (!row_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("row_ready_wait", 32'(row_ready), 32'd1);
      row_valid = 1'b1;
      row_data  = r;
      @(negedge clk);
      row_valid = 1'b0;
   endtask

   task automatic run_row(input logic [IW-1:0] r, input int n_exp_req,
                          input int stall_at, input int tsd_at);
      int got_sums = 0;
      int nreq = 0;
      int cyc = 0;
      int extra = 0;
      logic [SW-1:0] e;
      logic [2:0] ra;
      send_row(r);
      while (got_sums < ND && cyc < 400) begin
         ts_done = (cyc == tsd_at);
         if (ps_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (got_sums == stall_at) begin
               ps_ready = 1'b0;
               ra = w_raddr;
               for (int i = 0; i < 10; i++) begin
                  @(negedge clk);
                  check("stall_valid", 32'(ps_valid), 32'd1);
                  check("stall_data", 32'(ps_data), 32'(e));
                  check("stall_dest", 32'(ps_dest), 32'(exp_dest));
                  check("stall_raddr", 32'(w_raddr), 32'(ra));
               end
               ps_ready = 1'b1;
            end
            check("ps_data", 32'(ps_data), 32'(e));
            check("ps_dest", 32'(ps_dest), 32'(exp_dest));
            exp_dest = (exp_dest + 1) % FS;
            got_sums++;
         end
         @(negedge clk);
         cyc++;
      end
      ts_done = 1'b0;
      check("sum_count", 32'(got_sums), 32'(ND));
      check("ts_mid_row", 32'(ts), 32'(exp_ts));
      cyc = 0;
      while (busy && cyc < 20) begin
         if (req_valid) begin
            nreq++;
            check("req_dest", 32'(req_dest), 32'd10);
            check("req_pe_id", 32'(req_pe_id), 32'd0);
            check("req_excl_ps", 32'(ps_valid), 32'd0);
         end
         if (ps_valid) extra++;
         @(negedge clk);
         cyc++;
      end
      check("row_end_idle", 32'(busy), 32'd0);
      check("req_count", 32'(nreq), 32'(n_exp_req));
      check("extra_sums", 32'(extra), 32'd0);
   endtask

   task automatic pulse_ts_idle();
      ts_done = 1'b1;
      @(negedge clk);
      ts_done = 1'b0;
      exp_ts = (exp_ts == 1) ? 2 : 1;
      exp_dest = 0;
      check("ts_toggle", 32'(ts), 32'(exp_ts));
      check("ts_dest_clr", 32'(ps_dest), 32'd0);
      check("ts_row_ready", 32'(row_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt;
      int cyc;
      set_w(0, 0, 0, 0, 0);
      // reset state
      repeat (2) @(negedge clk);
      check("rst_row_ready", 32'(row_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ps_valid", 32'(ps_valid), 32'd0);
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_ts", 32'(ts), 32'd1);
      check("rst_ps_data", 32'(ps_data), 32'd0);
      check("rst_ps_dest", 32'(ps_dest), 32'd0);
      check("rst_raddr", 32'(w_raddr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("no_weights_gate", 32'(row_ready), 32'd0);
      weights_loaded = 1'b1;
      @(negedge clk);
      check("weights_ready", 32'(row_ready), 32'd1);

      // rows 1..5 of timestep 1: four IMEM requests, none after row 5
      set_w(1, 2, 3, 4, 5);
      fill(15, 15);
      run_row({IW{1'b1}}, 1, -1, -1);

      set_w(-3, 2, 3, 4, 5);
      fill(-3, 0);
      run_row(25'h0000001, 1, -1, -1);

      set_w(1, 2, 3, 4, 5);
      for (int i = 0; i < ND; i++) exp_q.push_back(SW'(0));
      exp_q[0] = 14'd8; exp_q[1] = 14'd5; exp_q[2] = 14'd3;
      exp_q[3] = 14'd2; exp_q[4] = 14'd1; exp_q[20] = 14'd5;
      run_row(25'h1000013, 1, -1, -1);

      set_w(-128, -128, -128, -128, -128);
      fill(-640, -640);
      run_row({IW{1'b1}}, 1, 7, -1);

      set_w(127, 127, 127, 127, 127);
      fill(635, 635);
      run_row({IW{1'b1}}, 0, -1, -1);

      // row held off once the timestep's rows are used up
      row_valid = 1'b1;
      row_data  = {IW{1'b1}};
      repeat (3) @(negedge clk);
      check("full_row_ready", 32'(row_ready), 32'd0);
      check("full_busy", 32'(busy), 32'd0);
      row_valid = 1'b0;
      pulse_ts_idle();

      // ts_done mid-MAC is deferred until the row completes
      set_w(1, 2, 3, 4, 5);
      fill(15, 15);
      run_row({IW{1'b1}}, 1, -1, 3);
      exp_ts = 1;
      exp_dest = 0;
      check("ts_deferred", 32'(ts), 32'd1);
      check("deferred_dest", 32'(ps_dest), 32'd0);

      // reset during window 7 discards the row
      pulse_ts_idle();
      send_row({IW{1'b1}});
      cnt = 0;
      cyc = 0;
      while (cnt < 7 && cyc < 200) begin
         if (ps_valid) cnt++;
         @(negedge clk);
         cyc++;
      end
      check("pre_reset_sums", 32'(cnt), 32'd7);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_ps_valid", 32'(ps_valid), 32'd0);
      check("mid_rst_req_valid", 32'(req_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ts", 32'(ts), 32'd1);
      check("mid_rst_ps_data", 32'(ps_data), 32'd0);
      check("mid_rst_dest", 32'(ps_dest), 32'd0);
      rst_n = 1'b1;
      exp_ts = 1;
      exp_dest = 0;
      exp_q.delete();
      @(negedge clk);
      fill(15, 15);
      run_row({IW{1'b1}}, 1, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ppe_conv_sequencer.md
Name: ppe_conv_sequencer

Overview:
Clocked controller that sequences one partial-PE's 1-D convolution. It accepts a 25-bit binary input row, then walks OUTPUT_DIM sliding windows of FILTER_SIZE taps. For each tap it issues reads to the weight register file and accumulates a signed partial sum. Each finished sum is emitted to the SPEs in round-robin order, and the next input row is requested from IMEM until a timestep's rows are exhausted.

Parameters:
FILTER_SIZE, 5, taps per window, also the number of SPE destinations and rows per timestep
IFMAP_SIZE, 25, input bits per row
WEIGHT_W, 8, signed weight width
SUM_W, 14, signed partial-sum width
PE_ID, 0, this PE's id, carried in IMEM requests
IMEM_ID, 10, IMEM node address

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
row_valid  in  1  new input row offered
row_ready  out  1  row accepted when row_valid&row_ready
row_data  in  IFMAP_SIZE  input spikes; bit k = input k
weights_loaded  in  1  level; weight RF holds all FILTER_SIZE weights
w_raddr  out  $clog2(FILTER_SIZE)  weight RF read address
w_rdata  in  WEIGHT_W  signed weight, valid exactly 1 cycle after w_raddr
ps_valid  out  1  partial sum available
ps_ready  in  1  downstream packetizer accepts
ps_data  out  SUM_W  signed partial sum
ps_dest  out  4  SPE id 0..FILTER_SIZE-1
req_valid  out  1  IMEM row request
req_ready  in  1  request accepted
req_dest  out  4  constant IMEM_ID
req_pe_id  out  4  constant PE_ID
ts_done  in  1  single-cycle pulse: timestep finished
ts  out  2  current timestep, 1 or 2
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n=0 at posedge), regardless of state:
  - state=IDLE; all valids 0; ps_data=0; ps_dest=0; w_raddr=0; ts=1; row count=0; pending_ts=0; busy=0.
  - A reset mid-MAC or mid-EMIT discards the current sum.
- row_ready=1 only in IDLE && weights_loaded && rows<FILTER_SIZE.
- On row acceptance: latch row_data into an internal register, rows++, win=0, go to MAC.
- MAC (FILTER_SIZE+1 cycles per window):
  - Cycles t=0..FILTER_SIZE-1 drive w_raddr=t.
  - Cycles t=1..FILTER_SIZE: acc += row[win+t-1] ? sext(w_rdata) : 0.
  - acc clears at window start.
  - Worst-case |sum| is 640, so with SUM_W>=11 no overflow is possible. No saturation logic.
- EMIT: ps_valid=1, ps_data=acc, ps_dest=dest.
  - ps_data and ps_dest stay stable until ps_ready.
  - On handshake: dest = (dest+1)%FILTER_SIZE; win++.
  - If win < IFMAP_SIZE-FILTER_SIZE+1, go to MAC; else go to ROWEND.
- ROWEND:
  - If rows<FILTER_SIZE, go to REQ.
  - Otherwise go to IDLE.
- REQ: req_valid=1 until req_ready, then IDLE. req_valid is never asserted in the same cycle as ps_valid.
- Latency per window: FILTER_SIZE+2 cycles minimum (MAC plus one EMIT cycle with ps_ready=1).
- ts_done handling:
  - In IDLE: ts toggles 1<->2, rows=0, dest=0 on the next edge.
  - When not IDLE: sets pending_ts, which is applied on entry to IDLE.
  - ts_done coincident with a row acceptance: the acceptance wins and ts_done becomes pending.
- weights_loaded dropping mid-row is ignored; it gates only row acceptance.
- row_valid while rows==FILTER_SIZE: row_ready stays 0 (row held off) until ts_done.

Decomposition:
- Package ppe_pkg:
  - State enum (IDLE, MAC, EMIT, ROWEND, REQ).
  - Constants: OP_WEIGHT=0, OP_INPUT=1, OP_TIMESTEP_DONE=15, IMEM_ID=10, WEIGHT_W=8, SUM_W=14.
  - Function output_dim(ifmap, filter) returning ifmap-filter+1.
- Sub-module ppe_mac_acc: tap counter, sign extension, accumulator, with start/done handshake to the FSM.
- FSM, row register and round-robin dest counter remain in the top module.

Test Plan:
- Weights {1,2,3,4,5}, row all ones, ps_ready=1 -> 21 sums of 15; ps_dest sequence 0,1,2,3,4,0,… ending at 0; then one req_valid with req_dest=10, req_pe_id=PE_ID.
- Row with only bit 0 set, w0=-3 -> first ps_data=14'h3FFD (-3), remaining 20 sums 0; all-ones row with weights -128 -> each sum -640; with weights 127 -> each sum 635.
- ps_ready held low 10 cycles during EMIT -> ps_valid, ps_data and ps_dest stable; w_raddr unchanged; no extra sums emitted.
- Five rows back-to-back -> exactly 4 IMEM requests; row_ready low after row 5; ts_done -> ts=2, dest=0, row_ready returns high.
- ts_done pulsed mid-MAC -> current row completes unchanged; ts toggles on entry to IDLE.
- rst_n low during MAC of window 7 -> next cycle all valids 0, ts=1, busy=0; a fresh row restarts at window 0 with dest 0.
